// File: rtl/fb_port_arbiter_if.sv
// fb_port_arbiter_if
//   Bundles every requester-side and RAM-side signal of the framebuffer
//   port arbiter.
//   - slave modport: the arbiter's view.
//     * inputs: VGA/capture/AI requests, ovf_clr, ram_q
//     * outputs: vga_q, cap_wr_ready, ai_rd_ack/ai_rd_data, ovf_sticky,
//       fifo_level, ram_addr/ram_we/ram_wdata
//   - master modport: the mirror view, used by the requesters and the RAM.
interface fb_port_arbiter_if #(
  parameter int ADDR_W     = 15,
  parameter int DATA_W     = 2,
  parameter int FIFO_LVL_W = 4
);
  logic              vga_rd_en;
  logic [ADDR_W-1:0] vga_addr;
  logic [DATA_W-1:0] vga_q;
  logic              cap_wr_valid;
  logic [ADDR_W-1:0] cap_wr_addr;
  logic [DATA_W-1:0] cap_wr_data;
  logic              cap_wr_ready;
  logic              ai_rd_req;
  logic [ADDR_W-1:0] ai_rd_addr;
  logic              ai_rd_ack;
  logic [DATA_W-1:0] ai_rd_data;
  logic              ovf_clr;
  logic              ovf_sticky;
  logic [FIFO_LVL_W-1:0] fifo_level;
  logic [ADDR_W-1:0] ram_addr;
  logic              ram_we;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_q;

  modport slave (
    input  vga_rd_en, vga_addr, cap_wr_valid, cap_wr_addr, cap_wr_data,
           ai_rd_req, ai_rd_addr, ovf_clr, ram_q,
    output vga_q, cap_wr_ready, ai_rd_ack, ai_rd_data, ovf_sticky,
           fifo_level, ram_addr, ram_we, ram_wdata
  );

  modport master (
    output vga_rd_en, vga_addr, cap_wr_valid, cap_wr_addr, cap_wr_data,
           ai_rd_req, ai_rd_addr, ovf_clr, ram_q,
    input  vga_q, cap_wr_ready, ai_rd_ack, ai_rd_data, ovf_sticky,
           fifo_level, ram_addr, ram_we, ram_wdata
  );
endinterface

// File: rtl/fb_port_arbiter.sv
// fb_port_arbiter
//   Shares the single-port Game Boy framebuffer RAM between three requesters,
//   issuing exactly one RAM operation per cycle.
//   - Priority: VGA reads > capture FIFO drain > AI reads.
//   - Capture writes are buffered in a small FIFO. Writes arriving while the
//     FIFO is full are dropped and flagged in ovf_sticky.
//   - AI reads use a req/ack handshake through a four-state FSM.
//   Ports:
//   - clk  : system/pixel clock
//   - rst_n: asynchronous reset, active low
//   - bus  : fb_port_arbiter_if.slave, carrying all requester and RAM signals
//   The RAM is synchronous with one cycle of read latency.
module fb_port_arbiter #(
  parameter int ADDR_W     = 15,
  parameter int DATA_W     = 2,
  parameter int FIFO_DEPTH = 8,
  parameter int FIFO_LVL_W = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  fb_port_arbiter_if.slave    bus
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } ai_state_t;

  logic [ADDR_W-1:0]     fifo_addr_r [FIFO_DEPTH];
  logic [DATA_W-1:0]     fifo_data_r [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr_r, rd_ptr_r;
  logic [FIFO_LVL_W-1:0] level_r;
  logic                  ovf_r;

  logic [ADDR_W-1:0] ram_addr_r;
  logic              ram_we_r;
  logic [DATA_W-1:0] ram_wdata_r;
  logic              vga_p1_r, vga_p2_r;
  logic [DATA_W-1:0] vga_q_r;

  ai_state_t         state_r, state_nxt_s;
  logic              ai_ack_r;
  logic [DATA_W-1:0] ai_data_r;

  logic ready_s, push_s, drop_s, fifo_empty_s;
  logic vga_gnt_s, fifo_gnt_s, ai_gnt_s;
  logic ai_issue_s, ai_resp_s;

  // FIFO handshake terms.
  always_comb begin
    fifo_empty_s = (level_r == {FIFO_LVL_W{1'b0}});
    ready_s      = (level_r < FIFO_LVL_W'(FIFO_DEPTH));
    push_s       = bus.cap_wr_valid & ready_s;
    drop_s       = bus.cap_wr_valid & ~ready_s;
  end

  // Slot grant: VGA first, then FIFO drain, then AI.
  // The AI may only read while the FIFO is empty, so it never sees stale pixels.
  // The grant looks at the registered level, so a pixel pushed this cycle
  // cannot be popped in the same cycle.
  always_comb begin
    vga_gnt_s  = bus.vga_rd_en;
    fifo_gnt_s = 1'b0;
    ai_gnt_s   = 1'b0;
    if (bus.vga_rd_en) begin
      fifo_gnt_s = 1'b0;
      ai_gnt_s   = 1'b0;
    end else if (!fifo_empty_s) begin
      fifo_gnt_s = 1'b1;
    end else begin
      ai_gnt_s = ai_issue_s;
    end
  end

  // FIFO storage. Entries are not reset; the level counter qualifies them.
  always_ff @(posedge clk) begin
    if (push_s) begin
      fifo_addr_r[wr_ptr_r] <= bus.cap_wr_addr;
      fifo_data_r[wr_ptr_r] <= bus.cap_wr_data;
    end
  end

  // FIFO pointers, level and overflow flag.
  // The pointers wrap naturally because FIFO_DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      level_r  <= {FIFO_LVL_W{1'b0}};
      ovf_r    <= 1'b0;
    end else begin
      if (push_s) wr_ptr_r <= wr_ptr_r + PTR_W'(1);
      if (fifo_gnt_s) rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      case ({push_s, fifo_gnt_s})
        2'b10:   level_r <= level_r + FIFO_LVL_W'(1);
        2'b01:   level_r <= level_r - FIFO_LVL_W'(1);
        default: level_r <= level_r;
      endcase
      // A drop beats a simultaneous clear.
      if (drop_s) ovf_r <= 1'b1;
      else if (bus.ovf_clr) ovf_r <= 1'b0;
    end
  end

  // Registered RAM command. The address holds when no slot is granted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ram_addr_r  <= {ADDR_W{1'b0}};
      ram_we_r    <= 1'b0;
      ram_wdata_r <= {DATA_W{1'b0}};
    end else if (vga_gnt_s) begin
      ram_addr_r <= bus.vga_addr;
      ram_we_r   <= 1'b0;
    end else if (fifo_gnt_s) begin
      ram_addr_r  <= fifo_addr_r[rd_ptr_r];
      ram_wdata_r <= fifo_data_r[rd_ptr_r];
      ram_we_r    <= 1'b1;
    end else if (ai_gnt_s) begin
      ram_addr_r <= bus.ai_rd_addr;
      ram_we_r   <= 1'b0;
    end else begin
      ram_we_r <= 1'b0;
    end
  end

  // VGA read pipeline.
  // Sequence: grant -> RAM command -> ram_q valid -> captured into vga_q.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vga_p1_r <= 1'b0;
      vga_p2_r <= 1'b0;
      vga_q_r  <= {DATA_W{1'b0}};
    end else begin
      vga_p1_r <= vga_gnt_s;
      vga_p2_r <= vga_p1_r;
      if (vga_p2_r) vga_q_r <= bus.ram_q;
    end
  end

  // AI FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_r <= ST_IDLE;
    else        state_r <= state_nxt_s;
  end

  // AI FSM next state.
  // IDLE ignores a request while the previous ack is still visible. The
  // requester drops ai_rd_req only after it sees the ack.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE:  state_nxt_s = (bus.ai_rd_req && !ai_ack_r) ? ST_ISSUE : ST_IDLE;
      ST_ISSUE: state_nxt_s = ai_gnt_s ? ST_WAIT : ST_ISSUE;
      ST_WAIT:  state_nxt_s = ST_RESP;
      ST_RESP:  state_nxt_s = ST_IDLE;
      default:  state_nxt_s = ST_IDLE;
    endcase
  end

  // AI FSM decoded outputs.
  always_comb begin
    ai_issue_s = (state_r == ST_ISSUE);
    ai_resp_s  = (state_r == ST_RESP);
  end

  // AI response registers. RESP is the cycle in which ram_q holds the AI read.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ai_ack_r  <= 1'b0;
      ai_data_r <= {DATA_W{1'b0}};
    end else begin
      ai_ack_r <= ai_resp_s;
      if (ai_resp_s) ai_data_r <= bus.ram_q;
    end
  end

  assign bus.vga_q        = vga_q_r;
  assign bus.cap_wr_ready = ready_s;
  assign bus.ai_rd_ack    = ai_ack_r;
  assign bus.ai_rd_data   = ai_data_r;
  assign bus.ovf_sticky   = ovf_r;
  assign bus.fifo_level   = level_r;
  assign bus.ram_addr     = ram_addr_r;
  assign bus.ram_we       = ram_we_r;
  assign bus.ram_wdata    = ram_wdata_r;
endmodule

// File: tb/tb_fb_port_arbiter.sv
// tb_fb_port_arbiter
//   Directed bench for fb_port_arbiter, with a behavioural synchronous RAM
//   model that has one cycle of read latency.
//   Inputs are driven 1 time unit after a rising edge and outputs are
//   sampled at that same point.
module tb_fb_port_arbiter;
  logic clk;
  logic rst_n;
  int   checks;
  int   failures;
  int   proto_err;
  logic ai_pend;

  fb_port_arbiter_if #(.ADDR_W(15), .DATA_W(2), .FIFO_LVL_W(4)) bus ();

  fb_port_arbiter #(.ADDR_W(15), .DATA_W(2), .FIFO_DEPTH(8), .FIFO_LVL_W(4)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM model. Locations that have never been written return their preload value.
  bit [1:0] mem [32768];
  bit       written [32768];

  function automatic logic [1:0] preload(input logic [14:0] a);
    if (a == 15'h0012) return 2'b10;
    else if (a == 15'h0100) return 2'b11;
    else return 2'b00;
  endfunction

  always @(posedge clk) begin
    if (bus.ram_we) begin
      mem[bus.ram_addr]     <= bus.ram_wdata;
      written[bus.ram_addr] <= 1'b1;
    end
    bus.ram_q <= written[bus.ram_addr] ? mem[bus.ram_addr] : preload(bus.ram_addr);
  end

  // Flags ai_rd_req falling before its ack.
  always @(negedge clk) begin
    if (!rst_n) begin
      ai_pend <= 1'b0;
    end else begin
      if (ai_pend && !bus.ai_rd_req && !bus.ai_rd_ack) begin
        proto_err <= proto_err + 1;
        $display("FAIL ai_req_drop: ai_rd_req=0 before ack at %0t", $time);
      end
      if (bus.ai_rd_ack) ai_pend <= 1'b0;
      else if (bus.ai_rd_req) ai_pend <= 1'b1;
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    bus.cap_wr_valid = 1'b1; bus.cap_wr_addr = 15'h0007; bus.cap_wr_data = 2'b11;
    step(3);
    checks++; if (bus.fifo_level !== 4'd0) begin failures++; $display("FAIL rst_level: got %0d want 0", bus.fifo_level); end
    checks++; if (bus.cap_wr_ready !== 1'b1) begin failures++; $display("FAIL rst_ready: got %b want 1", bus.cap_wr_ready); end
    checks++; if (bus.ram_we !== 1'b0) begin failures++; $display("FAIL rst_we: got %b want 0", bus.ram_we); end
    checks++; if (bus.ram_addr !== 15'h0000) begin failures++; $display("FAIL rst_addr: got %h want 0", bus.ram_addr); end
    checks++; if (bus.vga_q !== 2'b00) begin failures++; $display("FAIL rst_vga_q: got %b want 00", bus.vga_q); end
    checks++; if (bus.ai_rd_ack !== 1'b0 || bus.ai_rd_data !== 2'b00) begin failures++; $display("FAIL rst_ai: ack=%b data=%b want 0/00", bus.ai_rd_ack, bus.ai_rd_data); end
    checks++; if (bus.ovf_sticky !== 1'b0) begin failures++; $display("FAIL rst_ovf: got %b want 0", bus.ovf_sticky); end
    bus.cap_wr_valid = 1'b0;
    rst_n = 1'b1;
    step(2);
    checks++; if (bus.ram_we !== 1'b0 || bus.fifo_level !== 4'd0) begin failures++; $display("FAIL post_rst: we=%b level=%0d want 0/0", bus.ram_we, bus.fifo_level); end
  endtask

  task automatic test_vga;
    bus.vga_rd_en = 1'b1; bus.vga_addr = 15'h0012;
    step(1);
    checks++; if (bus.ram_we !== 1'b0 || bus.ram_addr !== 15'h0012) begin failures++; $display("FAIL vga_cmd: we=%b addr=%h want 0/0012", bus.ram_we, bus.ram_addr); end
    bus.vga_rd_en = 1'b0;
    step(1);
    checks++; if (bus.vga_q !== 2'b00) begin failures++; $display("FAIL vga_early: got %b want 00", bus.vga_q); end
    step(1);
    checks++; if (bus.vga_q !== 2'b10) begin failures++; $display("FAIL vga_q: got %b want 10", bus.vga_q); end
  endtask

  task automatic test_fifo_fill;
    logic [14:0] exp_addr [8];
    logic [1:0]  exp_data [8];
    int n;
    bus.vga_rd_en = 1'b1; bus.vga_addr = 15'h0030;
    for (int i = 0; i < 8; i++) begin
      exp_addr[i] = 15'h0200 + 15'(i);
      exp_data[i] = 2'((i % 3) + 1);
      bus.cap_wr_valid = 1'b1; bus.cap_wr_addr = exp_addr[i]; bus.cap_wr_data = exp_data[i];
      step(1);
    end
    checks++; if (bus.fifo_level !== 4'd8 || bus.cap_wr_ready !== 1'b0) begin failures++; $display("FAIL fifo_full: level=%0d ready=%b want 8/0", bus.fifo_level, bus.cap_wr_ready); end
    checks++; if (bus.ovf_sticky !== 1'b0) begin failures++; $display("FAIL ovf_early: got %b want 0", bus.ovf_sticky); end
    bus.cap_wr_addr = 15'h02FF; bus.cap_wr_data = 2'b11;
    step(1);
    bus.cap_wr_valid = 1'b0;
    checks++; if (bus.ovf_sticky !== 1'b1 || bus.fifo_level !== 4'd8) begin failures++; $display("FAIL ovf_set: ovf=%b level=%0d want 1/8", bus.ovf_sticky, bus.fifo_level); end
    step(160 - 9);
    checks++; if (bus.fifo_level !== 4'd8) begin failures++; $display("FAIL vga_blocks_drain: level=%0d want 8", bus.fifo_level); end
    bus.vga_rd_en = 1'b0;
    n = 0;
    for (int c = 0; c < 12; c++) begin
      step(1);
      if (bus.ram_we === 1'b1) begin
        checks++;
        if (n >= 8) begin
          failures++; $display("FAIL drain_extra: write %0d to %h", n, bus.ram_addr);
        end else if (bus.ram_addr !== exp_addr[n] || bus.ram_wdata !== exp_data[n]) begin
          failures++; $display("FAIL drain_order: #%0d got %h/%b want %h/%b", n, bus.ram_addr, bus.ram_wdata, exp_addr[n], exp_data[n]);
        end
        n++;
      end
    end
    checks++; if (n != 8) begin failures++; $display("FAIL drain_count: got %0d want 8", n); end
    checks++; if (bus.fifo_level !== 4'd0 || bus.cap_wr_ready !== 1'b1) begin failures++; $display("FAIL drain_empty: level=%0d ready=%b want 0/1", bus.fifo_level, bus.cap_wr_ready); end
  endtask

  task automatic test_ai_coherent;
    logic       got;
    logic [1:0] data;
    int acks;
    got = 1'b0; data = 2'b00; acks = 0;
    bus.cap_wr_valid = 1'b1; bus.cap_wr_addr = 15'h0100; bus.cap_wr_data = 2'b01;
    bus.ai_rd_req = 1'b1; bus.ai_rd_addr = 15'h0100;
    step(1);
    bus.cap_wr_valid = 1'b0;
    for (int c = 0; c < 20 && !got; c++) begin
      step(1);
      if (bus.ai_rd_ack === 1'b1) begin got = 1'b1; data = bus.ai_rd_data; end
    end
    bus.ai_rd_req = 1'b0;
    checks++; if (got !== 1'b1) begin failures++; $display("FAIL ai_coh_ack: no ack within 20 cycles"); end
    checks++; if (data !== 2'b01) begin failures++; $display("FAIL ai_coh_data: got %b want 01", data); end
    for (int c = 0; c < 5; c++) begin
      step(1);
      if (bus.ai_rd_ack === 1'b1) acks++;
    end
    checks++; if (acks != 0) begin failures++; $display("FAIL ai_coh_single: extra acks %0d want 0", acks); end
  endtask

  task automatic test_ai_starve;
    int acks;
    acks = 0;
    bus.vga_rd_en = 1'b1; bus.vga_addr = 15'h0030;
    bus.ai_rd_req = 1'b1; bus.ai_rd_addr = 15'h0012;
    for (int c = 0; c < 144; c++) begin
      step(1);
      if (bus.ai_rd_ack === 1'b1) acks++;
    end
    checks++; if (acks != 0) begin failures++; $display("FAIL ai_starved: acks=%0d want 0", acks); end
    bus.vga_rd_en = 1'b0;
    step(2);
    checks++; if (bus.ai_rd_ack !== 1'b0) begin failures++; $display("FAIL ai_ack_early: got %b want 0", bus.ai_rd_ack); end
    step(1);
    checks++; if (bus.ai_rd_ack !== 1'b1 || bus.ai_rd_data !== 2'b10) begin failures++; $display("FAIL ai_ack: ack=%b data=%b want 1/10", bus.ai_rd_ack, bus.ai_rd_data); end
    bus.ai_rd_req = 1'b0;
    step(1);
    checks++; if (bus.ai_rd_ack !== 1'b0) begin failures++; $display("FAIL ai_ack_pulse: got %b want 0", bus.ai_rd_ack); end
  endtask

  task automatic test_ovf;
    bus.ovf_clr = 1'b1;
    step(1);
    bus.ovf_clr = 1'b0;
    checks++; if (bus.ovf_sticky !== 1'b0) begin failures++; $display("FAIL ovf_clr: got %b want 0", bus.ovf_sticky); end
    bus.vga_rd_en = 1'b1; bus.vga_addr = 15'h0030;
    for (int i = 0; i < 8; i++) begin
      bus.cap_wr_valid = 1'b1; bus.cap_wr_addr = 15'h0400 + 15'(i); bus.cap_wr_data = 2'b10;
      step(1);
    end
    bus.ovf_clr = 1'b1;
    step(1);
    bus.ovf_clr = 1'b0; bus.cap_wr_valid = 1'b0;
    checks++; if (bus.ovf_sticky !== 1'b1) begin failures++; $display("FAIL ovf_drop_wins: got %b want 1", bus.ovf_sticky); end
    bus.vga_rd_en = 1'b0;
    step(10);
    checks++; if (bus.fifo_level !== 4'd0) begin failures++; $display("FAIL ovf_drain: level=%0d want 0", bus.fifo_level); end
    bus.ovf_clr = 1'b1;
    step(1);
    bus.ovf_clr = 1'b0;
    checks++; if (bus.ovf_sticky !== 1'b0) begin failures++; $display("FAIL ovf_clr2: got %b want 0", bus.ovf_sticky); end
  endtask

  initial begin
    checks = 0; failures = 0; proto_err = 0;
    rst_n = 1'b0;
    bus.vga_rd_en = 1'b0; bus.vga_addr = 15'h0000;
    bus.cap_wr_valid = 1'b0; bus.cap_wr_addr = 15'h0000; bus.cap_wr_data = 2'b00;
    bus.ai_rd_req = 1'b0; bus.ai_rd_addr = 15'h0000;
    bus.ovf_clr = 1'b0;
    test_reset();
    test_vga();
    test_fifo_fill();
    test_ai_coherent();
    test_ai_starve();
    test_ovf();
    step(2);
    checks++; if (proto_err != 0) begin failures++; $display("FAIL ai_protocol: %0d violations want 0", proto_err); end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
